// File: rtl/osd_trace_packetizer.sv
// Trace packetizer: turns one trace sample (or overflow record) into a DII event
// packet of 16-bit flits: DEST, SRC, TYPE header followed by LSB-first payload.

package osd_trace_packetizer_pkg;

    // One Debug Interconnect flit as presented to the register-access layer
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

module osd_trace_packetizer
    import osd_trace_packetizer_pkg::*;
#(
    parameter int unsigned WIDTH = 135,
    parameter logic [15:0] DEST  = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       id,
    input  logic [WIDTH-1:0] trace_data,
    input  logic             trace_overflow,
    input  logic             trace_valid,
    output logic             trace_ready,
    output dii_flit          debug_out,
    input  logic             debug_out_ready
);

    localparam int unsigned NUM_FLITS = (WIDTH + 15) / 16;
    localparam int unsigned CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
    localparam int unsigned PAD_W     = NUM_FLITS * 16;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FLITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEST,
        S_SRC,
        S_TYPE,
        S_PAYLOAD
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAD_W-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic [9:0]       id_q, id_d;
    dii_flit          flit_q, flit_d;
    logic             ready_q, ready_d;
    logic [15:0]      pay_flit;

    // State, capture and registered-output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            id_q    <= '0;
            flit_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            id_q    <= id_d;
            flit_q  <= flit_d;
            ready_q <= ready_d;
        end
    end

    // Next-state: capture in IDLE, then walk header and payload on each accepted flit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        id_d    = id_q;
        unique case (state_q)
            S_IDLE: begin
                if (trace_valid) begin
                    data_d  = PAD_W'(trace_data);
                    ovf_d   = trace_overflow;
                    id_d    = id;
                    cnt_d   = '0;
                    state_d = S_DEST;
                end
            end
            S_DEST: begin
                if (debug_out_ready) state_d = S_SRC;
            end
            S_SRC: begin
                if (debug_out_ready) state_d = S_TYPE;
            end
            S_TYPE: begin
                if (debug_out_ready) state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (debug_out_ready) begin
                    if (ovf_q || (cnt_q == LAST_CNT)) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Payload word selected by the next counter value (zero padding comes from capture)
    always_comb begin
        pay_flit = '0;
        for (int unsigned k = 0; k < NUM_FLITS; k++) begin
            if (cnt_d == CNT_W'(k)) pay_flit = data_d[16*k +: 16];
        end
    end

    // Output decode from the next state so the flit register matches the state register
    always_comb begin
        flit_d  = '0;
        ready_d = (state_d == S_IDLE);
        unique case (state_d)
            S_DEST: begin
                flit_d.valid = 1'b1;
                flit_d.data  = DEST;
            end
            S_SRC: begin
                flit_d.valid = 1'b1;
                flit_d.data  = {6'b0, id_d};
            end
            S_TYPE: begin
                flit_d.valid = 1'b1;
                flit_d.data  = {2'b10, (ovf_d ? 4'h5 : 4'h0), 10'b0};
            end
            S_PAYLOAD: begin
                flit_d.valid = 1'b1;
                flit_d.last  = ovf_d || (cnt_d == LAST_CNT);
                flit_d.data  = pay_flit;
            end
            default: flit_d = '0;
        endcase
    end

    assign debug_out   = flit_q;
    assign trace_ready = ready_q;

endmodule
